bcd_result_converter: RTL and testbench

- Downstream stage of the factorial unit. Consumes its 16-bit result and Done flag.
- Converts the captured binary result to packed BCD using sequential shift-and-add-3 (double dabble), one bit per clock.
- Holds the BCD value stable for the display/seven-segment stage, with a one-cycle Valid strobe and a Busy flag.

---
 rtl/bcd_result_converter_if.sv | 14 +
 rtl/bcd_result_converter.sv | 96 +++++++++
 tb/tb_bcd_result_converter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bcd_result_converter_if.sv
// bcd_result_converter_if: factorial result handshake in, held BCD/Valid/Busy out
interface bcd_result_converter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  Done;
    logic [WIDTH-1:0]      Result;
    logic [4*DIGITS-1:0]   BCD;
    logic                  Valid;
    logic                  Busy;

    modport master (output Done, Result, input BCD, Valid, Busy);
    modport slave  (input Done, Result, output BCD, Valid, Busy);
endinterface

// File: rtl/bcd_result_converter.sv
// bcd_result_converter: Done-edge-triggered double-dabble binary to BCD, one bit per clock
module bcd_result_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input logic CLK,
    input logic RST_N,
    bcd_result_converter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
    localparam int CW = $clog2(WIDTH + 1);

    state_t              state_q, state_d;
    logic                done_q, arm_q, pend_q, pend_d, valid_q, valid_d, trig;
    logic [WIDTH-1:0]    bin_q, bin_d, pval_q, pval_d;
    logic [4*DIGITS-1:0] work_q, work_d, bcd_q, bcd_d, adj;
    logic [CW-1:0]       cnt_q, cnt_d;

    // arm_q blocks a trigger until Done has been seen low since reset
    assign trig = bus.Done & ~done_q & arm_q;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign adj[4*d +: 4] = work_q[4*d +: 4] >= 4'd5 ? work_q[4*d +: 4] + 4'd3 : work_q[4*d +: 4];
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        pend_d  = pend_q;
        pval_d  = pval_q;
        if (trig && state_q != IDLE) begin
            pend_d = 1'b1;
            pval_d = bus.Result;
        end
        case (state_q)
            IDLE: if (trig) begin
                bin_d   = bus.Result;
                work_d  = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                {work_d, bin_d} = {adj, bin_q} << 1;
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(WIDTH - 1) ? FINISH : SHIFT;
            end
            FINISH: begin
                bcd_d   = work_q;
                valid_d = 1'b1;
                // a trigger landing on this edge is already folded into pend_d/pval_d
                if (pend_d) begin
                    pend_d  = 1'b0;
                    bin_d   = pval_d;
                    work_d  = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            arm_q   <= 1'b0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            bin_q   <= '0;
            pval_q  <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= bus.Done;
            arm_q   <= arm_q | ~bus.Done;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            bin_q   <= bin_d;
            pval_q  <= pval_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.BCD   = bcd_q;
    assign bus.Valid = valid_q;
    assign bus.Busy  = state_q != IDLE;
endmodule

// File: tb/tb_bcd_result_converter.sv
// tb_bcd_result_converter: table-driven and sequence checks of the BCD converter
module tb_bcd_result_converter;
    logic CLK, RST_N;
    int   tests, fails;
    logic [19:0] last_bcd;

    bcd_result_converter_if #(.WIDTH(16), .DIGITS(5)) bus();
    bcd_result_converter #(.WIDTH(16), .DIGITS(5)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] r;
        logic [19:0] b;
        int          hold;
    } vec_t;
    vec_t vec[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] b;
        b = '0;
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return b;
    endfunction

    // Called on a negedge with Done low; Done rises now, trigger on the next posedge (k=1)
    task automatic run_one(input logic [15:0] r, input logic [19:0] exp, input int hold, input string nm);
        int vcnt, first;
        vcnt = 0;
        first = 0;
        bus.Result = r;
        bus.Done = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge CLK);
            if (k == hold) bus.Done = 1'b0;
            if (bus.Valid) begin
                vcnt++;
                if (first == 0) first = k;
            end
            if (k == 10) chk({nm, "_held"}, bus.BCD, last_bcd);
            if (k == 17) chk({nm, "_busy_hi"}, bus.Busy, 1);
            if (k == 18) chk({nm, "_busy_lo"}, bus.Busy, 0);
        end
        chk({nm, "_latency"}, first, 18);
        chk({nm, "_vcount"}, vcnt, 1);
        chk({nm, "_bcd"}, bus.BCD, exp);
        last_bcd = exp;
    endtask

    initial begin
        int vcnt, blow;
        logic [15:0] r;
        tests = 0;
        fails = 0;
        last_bcd = '0;
        vec[0]  = '{16'd0,     20'h00000, 2};
        vec[1]  = '{16'd120,   20'h00120, 10};
        vec[2]  = '{16'd40320, 20'h40320, 2};
        vec[3]  = '{16'd65535, 20'h65535, 2};
        vec[4]  = '{16'd9,     20'h00009, 1};
        vec[5]  = '{16'd10,    20'h00010, 2};
        vec[6]  = '{16'd99,    20'h00099, 25};
        vec[7]  = '{16'd100,   20'h00100, 2};
        vec[8]  = '{16'd9999,  20'h09999, 2};
        vec[9]  = '{16'd10000, 20'h10000, 2};
        vec[10] = '{16'd720,   20'h00720, 2};
        vec[11] = '{16'd5040,  20'h05040, 2};
        vec[12] = '{16'd1,     20'h00001, 2};
        vec[13] = '{16'd59049, 20'h59049, 2};

        RST_N = 1'b0;
        bus.Done = 1'b0;
        bus.Result = '0;
        repeat (3) @(negedge CLK);
        chk("rst_bcd", bus.BCD, 0);
        chk("rst_valid", bus.Valid, 0);
        chk("rst_busy", bus.Busy, 0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        foreach (vec[i]) run_one(vec[i].r, vec[i].b, vec[i].hold, $sformatf("vec%0d", i));

        // two in flight: 720 at edge 1, 5040 at edge 5
        vcnt = 0;
        blow = 0;
        bus.Result = 16'd720;
        bus.Done = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 1 || k == 5) bus.Done = 1'b0;
            if (k == 4) begin bus.Result = 16'd5040; bus.Done = 1'b1; end
            if (bus.Valid) vcnt++;
            if (k <= 34 && !bus.Busy) blow++;
            if (k == 18) begin chk("pair_v1", bus.Valid, 1); chk("pair_bcd1", bus.BCD, 20'h00720); end
            if (k == 25) chk("pair_hold", bus.BCD, 20'h00720);
            if (k == 35) begin chk("pair_v2", bus.Valid, 1); chk("pair_bcd2", bus.BCD, 20'h05040); chk("pair_busy_lo", bus.Busy, 0); end
        end
        chk("pair_vcount", vcnt, 2);
        chk("pair_busy_gap", blow, 0);

        // trigger on the FINISH edge, plus latest-wins pending overwrite
        vcnt = 0;
        blow = 0;
        bus.Result = 16'd9;
        bus.Done = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 1 || k == 5 || k == 18) bus.Done = 1'b0;
            if (k == 4) begin bus.Result = 16'd10; bus.Done = 1'b1; end
            if (k == 17) begin bus.Result = 16'd99; bus.Done = 1'b1; end
            if (bus.Valid) vcnt++;
            if (k <= 34 && !bus.Busy) blow++;
            if (k == 18) chk("fin_bcd1", bus.BCD, 20'h00009);
            if (k == 35) chk("fin_bcd2", bus.BCD, 20'h00099);
        end
        chk("fin_vcount", vcnt, 2);
        chk("fin_busy_gap", blow, 0);

        // reset mid-conversion of 24, Done kept high through and after release
        bus.Result = 16'd24;
        bus.Done = 1'b1;
        repeat (8) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("mrst_bcd", bus.BCD, 0);
        chk("mrst_busy", bus.Busy, 0);
        chk("mrst_valid", bus.Valid, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        last_bcd = '0;
        vcnt = 0;
        blow = 0;
        repeat (25) begin
            @(negedge CLK);
            if (bus.Valid) vcnt++;
            if (bus.Busy) blow++;
        end
        chk("mrst_no_valid", vcnt, 0);
        chk("mrst_no_busy", blow, 0);
        bus.Done = 1'b0;
        @(negedge CLK);
        run_one(16'd24, 20'h00024, 2, "mrst_retrig");

        for (int i = 0; i < 60; i++) begin
            r = 16'($urandom_range(0, 65535));
            run_one(r, to_bcd(int'(r)), 2, $sformatf("rnd%0d_%0d", i, r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
